// File: rtl/led_blinker.sv
// LED blinker: queues blink requests and plays each one as a fixed-length ON
// pulse followed by a forced OFF gap, dropping requests once the queue is full.
module led_blinker #(
    parameter int unsigned ON_CYCLES  = 4,
    parameter int unsigned OFF_CYCLES = 2,
    parameter int unsigned MAX_PEND   = 3
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_ev,
    output logic       o_led,
    output logic       o_busy,
    output logic [1:0] o_pend,
    output logic       o_drop
);

    typedef enum logic [1:0] {
        IDLE,
        ON,
        GAP
    } state_t;

    localparam logic [7:0] ON_LOAD  = 8'(ON_CYCLES - 1);
    localparam logic [7:0] OFF_LOAD = 8'(OFF_CYCLES - 1);
    localparam logic [1:0] PEND_MAX = 2'(MAX_PEND);

    state_t     state;
    state_t     state_next;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic [1:0] pend;
    logic [1:0] pend_next;
    logic       consume;
    logic       accept;

    // Next-state logic; a consume event pulls one request out of the queue
    // to start a blink, which frees a slot for a same-cycle request.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        consume    = 1'b0;
        case (state)
            IDLE: begin
                if (pend != 2'd0) begin
                    consume    = 1'b1;
                    state_next = ON;
                    cnt_next   = ON_LOAD;
                end
            end
            ON: begin
                if (cnt != 8'd0) begin
                    cnt_next = cnt - 8'd1;
                end else begin
                    state_next = GAP;
                    cnt_next   = OFF_LOAD;
                end
            end
            GAP: begin
                if (cnt != 8'd0) begin
                    cnt_next = cnt - 8'd1;
                end else if (pend != 2'd0) begin
                    consume    = 1'b1;
                    state_next = ON;
                    cnt_next   = ON_LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase

        accept    = in_ev && ((pend < PEND_MAX) || consume);
        pend_next = pend;
        if (accept && !consume) begin
            pend_next = pend + 2'd1;
        end else if (!accept && consume) begin
            pend_next = pend - 2'd1;
        end
    end

    // Outputs are registered from next-state values so they line up with state.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            pend   <= 2'd0;
            o_led  <= 1'b0;
            o_busy <= 1'b0;
            o_drop <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            pend   <= pend_next;
            o_led  <= (state_next == ON);
            o_busy <= (state_next != IDLE) || (pend_next != 2'd0);
            o_drop <= in_ev && !accept;
        end
    end

    assign o_pend = pend;

endmodule

// File: tb/tb_led_blinker.sv
// Directed self-checking bench for led_blinker with default parameters
// (ON_CYCLES=4, OFF_CYCLES=2, MAX_PEND=3).
module tb_led_blinker;

    logic       in_clk;
    logic       in_rst;
    logic       in_ev;
    logic       o_led;
    logic       o_busy;
    logic [1:0] o_pend;
    logic       o_drop;

    int checks;
    int errors;

    led_blinker dut (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .in_ev  (in_ev),
        .o_led  (o_led),
        .o_busy (o_busy),
        .o_pend (o_pend),
        .o_drop (o_drop)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    // Drive inputs for one edge, then settle just past it before sampling.
    task automatic applyStimulus(input logic ev, input logic rst);
        in_ev  = ev;
        in_rst = rst;
        @(posedge in_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic resetDut();
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        in_rst = 1'b0;
    endtask

    logic [0:7]  led31;
    logic [0:19] led32;
    logic [0:19] ev32;
    int          rises;
    int          drops;
    int          led_high;
    logic [1:0]  pend_max;
    logic        prev_led;

    initial begin
        checks = 0;
        errors = 0;
        in_ev  = 1'b0;
        in_rst = 1'b1;

        // Reset with in_ev toggling: everything stays quiet.
        applyStimulus(1'b1, 1'b1);
        checkOutput("rst1_led", 8'(o_led), 8'd0);
        checkOutput("rst1_pend", 8'(o_pend), 8'd0);
        checkOutput("rst1_busy", 8'(o_busy), 8'd0);
        checkOutput("rst1_drop", 8'(o_drop), 8'd0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("rst2_led", 8'(o_led), 8'd0);
        checkOutput("rst2_pend", 8'(o_pend), 8'd0);
        checkOutput("rst2_busy", 8'(o_busy), 8'd0);
        checkOutput("rst2_drop", 8'(o_drop), 8'd0);

        // Single pulse at edge 1.
        led31 = 8'b0111_1000;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i == 0, 1'b0);
            checkOutput($sformatf("single_led_e%0d", i + 1), 8'(o_led), 8'(led31[i]));
            if (i == 0) checkOutput("single_pend_e1", 8'(o_pend), 8'd1);
            if (i == 6) checkOutput("single_busy_e7", 8'(o_busy), 8'd1);
            if (i == 7) checkOutput("single_busy_e8", 8'(o_busy), 8'd0);
        end

        // Pulses at edges 1, 3, 4: three blinks with 2-cycle gaps.
        resetDut();
        ev32  = 20'b1011_0000_0000_0000_0000;
        led32 = 20'b0111_1001_1110_0111_1000;
        pend_max = 2'd0;
        drops = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(ev32[i], 1'b0);
            checkOutput($sformatf("three_led_e%0d", i + 1), 8'(o_led), 8'(led32[i]));
            if (o_pend > pend_max) pend_max = o_pend;
            if (o_drop) drops++;
        end
        checkOutput("three_pend_peak", 8'(pend_max), 8'd2);
        checkOutput("three_drops", 8'(drops), 8'd0);
        checkOutput("three_busy_end", 8'(o_busy), 8'd0);

        // in_ev held for 6 cycles: queue fills, two requests dropped.
        resetDut();
        rises = 0;
        drops = 0;
        pend_max = 2'd0;
        prev_led = 1'b0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(i < 6, 1'b0);
            if (o_led && !prev_led) rises++;
            prev_led = o_led;
            if (o_drop) drops++;
            if (o_pend > pend_max) pend_max = o_pend;
            if (i == 4) checkOutput("hold_drop_e5", 8'(o_drop), 8'd1);
        end
        checkOutput("hold_blinks", 8'(rises), 8'd4);
        checkOutput("hold_drops", 8'(drops), 8'd2);
        checkOutput("hold_pend_peak", 8'(pend_max), 8'd3);
        checkOutput("hold_busy_end", 8'(o_busy), 8'd0);

        // Full queue with a request landing on the GAP-end consume edge.
        resetDut();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("full_pend_e4", 8'(o_pend), 8'd3);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("full_led_e6", 8'(o_led), 8'd0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("full_pend_e8", 8'(o_pend), 8'd3);
        checkOutput("full_drop_e8", 8'(o_drop), 8'd0);
        checkOutput("full_led_e8", 8'(o_led), 8'd1);

        // Reset during the 3rd ON cycle with two requests queued.
        resetDut();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("midrst_pend_e3", 8'(o_pend), 8'd2);
        applyStimulus(1'b0, 1'b0);
        checkOutput("midrst_led_e4", 8'(o_led), 8'd1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("midrst_led_e5", 8'(o_led), 8'd0);
        checkOutput("midrst_pend_e5", 8'(o_pend), 8'd0);
        checkOutput("midrst_busy_e5", 8'(o_busy), 8'd0);
        led_high = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b0);
            if (o_led) led_high++;
        end
        checkOutput("midrst_no_blink", 8'(led_high), 8'd0);
        checkOutput("midrst_busy_end", 8'(o_busy), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_blinker.md
LED_BLINKER -- requirements
Module: led_blinker

Interface
REQ-001 The block SHALL have parameter ON_CYCLES, default 4, giving the LED-on length in clock cycles (legal range 1..255).
REQ-002 The block SHALL have parameter OFF_CYCLES, default 2, giving the forced LED-off gap between blinks in clock cycles (legal range 1..255).
REQ-003 The block SHALL have parameter MAX_PEND, default 3, giving the pending-request queue depth (legal range 1..3).
REQ-004 The block SHALL have port in_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port in_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_ev, input, 1 bit: blink request, sampled every rising edge; each sampled high counts as one request.
REQ-007 The block SHALL have port o_led, output, 1 bit: registered LED drive, high only in state ON.
REQ-008 The block SHALL have port o_busy, output, 1 bit: high when the state is not IDLE or pend is not 0.
REQ-009 The block SHALL have port o_pend, output, 2 bits: current pending-request count.
REQ-010 The block SHALL have port o_drop, output, 1 bit: registered one-cycle pulse marking a rejected request.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, ON and GAP.
REQ-012 The block SHALL use an 8-bit down-counter cnt to time ON and GAP.
REQ-013 Consume event: in IDLE with pend>0, the next state SHALL be ON, cnt SHALL load ON_CYCLES-1, and pend SHALL decrement.
REQ-014 In ON, while cnt>0, cnt SHALL decrement; at cnt==0 the next state SHALL be GAP with cnt loaded with OFF_CYCLES-1.
REQ-015 In GAP, while cnt>0, cnt SHALL decrement.
REQ-016 In GAP at cnt==0 with pend>0, the next state SHALL be ON, cnt SHALL load ON_CYCLES-1, and pend SHALL decrement (a consume event).
REQ-017 In GAP at cnt==0 with pend==0, the next state SHALL be IDLE.
REQ-018 o_led SHALL be high for exactly ON_CYCLES consecutive cycles per blink.
REQ-019 Consecutive blinks SHALL be separated by exactly OFF_CYCLES low cycles.
REQ-020 Latency: in_ev sampled at edge k with the block idle and pend==0 SHALL give o_pend=1 after edge k and o_led=1 after edge k+1.
REQ-021 A request SHALL be accepted when in_ev=1 and either pend<MAX_PEND or a consume event occurs in the same cycle.
REQ-022 Simultaneous accept and consume SHALL leave pend unchanged.
REQ-023 Full case: in_ev=1 with pend==MAX_PEND and no consume that cycle SHALL discard the request, leave pend unchanged, and set o_drop=1 for the following cycle only.
REQ-024 pend SHALL never exceed MAX_PEND and SHALL never wrap below 0.
REQ-025 in_ev held high for N cycles SHALL count as N requests, subject to REQ-021 and REQ-023.
REQ-026 Requests arriving during ON or GAP SHALL be queued and SHALL NOT extend or restart the blink in progress.

Reset
REQ-027 When in_rst=1 at an edge, the state SHALL become IDLE and cnt, pend, o_led, o_busy, o_pend and o_drop SHALL all become 0.
REQ-028 While in_rst=1, in_ev SHALL be ignored, including in the same cycle.
REQ-029 Reset asserted mid-blink SHALL force o_led=0 after that edge; no blink resumes and queued requests are lost.

Verification (defaults ON=4, OFF=2, MAX=3)
REQ-030 Scenario: in_rst=1 for 2 cycles with in_ev toggling -> o_led=0, o_pend=0, o_busy=0, o_drop=0 throughout.
REQ-031 Scenario: single in_ev pulse at edge 1 -> o_pend=1 after edge 1; o_led=1 after edges 2..5; o_led=0 after edges 6..7; o_busy=0 after edge 8.
REQ-032 Scenario: in_ev pulses at edges 1, 3 and 4 -> three 4-cycle blinks with exactly 2 low cycles between them; o_pend peaks at 2; o_drop is never asserted.
REQ-033 Scenario: in_ev held high for 6 cycles from idle -> o_pend reaches 3; exactly 2 o_drop pulses; exactly 4 blinks total.
REQ-034 Scenario: pend==3 and in_ev=1 in the cycle GAP ends (consume) -> request accepted, o_pend stays 3, no o_drop.
REQ-035 Scenario: in_rst asserted during the 3rd ON cycle with pend=2 -> o_led=0 and o_pend=0 after that edge; no further blinks without new in_ev.
